// File: rtl/fpcvt_pkg.sv
// Shared constants and FSM state type for the fpcvt arbiter slice.
package fpcvt_pkg;

  localparam int unsigned FP_IN_W = 12;
  localparam int unsigned FP_E_W  = 3;
  localparam int unsigned FP_F_W  = 4;

  localparam logic [FP_E_W-1:0] FP_SAT_E = 3'd7;
  localparam logic [FP_F_W-1:0] FP_SAT_F = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CVT  = 2'd1,
    ST_HOLD = 2'd2
  } fpcvt_state_e;

endpackage

// File: rtl/fp8_encode.sv
// Combinational 12-bit two's-complement to 8-bit float {S,E[2:0],F[3:0]}
// conversion with round-half-up and saturation flag.
module fp8_encode
  import fpcvt_pkg::*;
(
  input  logic [FP_IN_W-1:0] d_i,
  output logic               s_o,
  output logic [FP_E_W-1:0]  e_o,
  output logic [FP_F_W-1:0]  f_o,
  output logic               sat_o
);

  logic [FP_IN_W-1:0] mag;
  logic [3:0]         k;
  logic               found;
  // One spare bit on each field catches mantissa carry and exponent overflow.
  logic [FP_E_W:0]    e_w;
  logic [FP_F_W:0]    f_w;

  always_comb begin
    mag   = d_i[FP_IN_W-1] ? (~d_i + FP_IN_W'(1)) : d_i;
    found = 1'b0;
    k     = 4'd0;
    for (int unsigned i = 4; i <= 10; i++) begin
      if (mag[i]) begin
        found = 1'b1;
        k     = 4'(i);
      end
    end

    e_w = '0;
    f_w = '0;
    if (mag[11]) begin
      e_w = {1'b0, FP_SAT_E};
      f_w = {1'b0, FP_SAT_F};
    end else if (!found) begin
      f_w = {1'b0, mag[3:0]};
    end else begin
      e_w = k - 4'd3;
      f_w = {1'b0, mag[k -: 4]};
      if (mag[k - 4'd4]) begin
        f_w = f_w + 5'd1;
      end
      if (f_w[FP_F_W]) begin
        f_w = 5'd8;
        e_w = e_w + 4'd1;
      end
      if (e_w[FP_E_W]) begin
        e_w = {1'b0, FP_SAT_E};
        f_w = {1'b0, FP_SAT_F};
      end
    end
  end

  assign s_o   = d_i[FP_IN_W-1];
  assign e_o   = e_w[FP_E_W-1:0];
  assign f_o   = f_w[FP_F_W-1:0];
  assign sat_o = (e_o == FP_SAT_E) && (f_o == FP_SAT_F);

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin arbiter sharing one fp8_encode datapath among NREQ requesters.
// Optional saturation counter enabled by FPCVT_SAT_STATS_EN.
module fpcvt_arbiter
  import fpcvt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [FP_IN_W*NREQ-1:0] req_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_s,
  output logic [FP_E_W-1:0]       out_e,
  output logic [FP_F_W-1:0]       out_f,
  output logic [IDW-1:0]          out_id,
  output logic                    busy,
  output logic [15:0]             sat_count
);

  fpcvt_state_e       state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [FP_IN_W-1:0] data_q;
  logic [IDW-1:0]     id_q;
  logic               out_valid_q;
  logic               out_s_q;
  logic [FP_E_W-1:0]  out_e_q;
  logic [FP_F_W-1:0]  out_f_q;
  logic [IDW-1:0]     out_id_q;

  logic               any_req;
  logic               grant;
  logic [IDW-1:0]     win;
  logic [FP_IN_W-1:0] win_data;

  logic               enc_s;
  logic [FP_E_W-1:0]  enc_e;
  logic [FP_F_W-1:0]  enc_f;

  // Offset i is the search priority from rr_ptr; j only selects constant indices.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any_req && req_valid[j] && (((32'(rr_ptr_q) + i) % NREQ) == j)) begin
          any_req  = 1'b1;
          win      = IDW'(j);
          win_data = req_data[j*FP_IN_W +: FP_IN_W];
        end
      end
    end
  end

  assign grant     = rst_n && any_req &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign req_ready = grant ? (NREQ'(1) << win) : '0;
  assign rr_ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_CVT;
      ST_CVT:  state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = grant ? ST_CVT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      out_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        data_q   <= win_data;
        id_q     <= win;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == ST_CVT) begin
        out_valid_q <= 1'b1;
        out_s_q     <= enc_s;
        out_e_q     <= enc_e;
        out_f_q     <= enc_f;
        out_id_q    <= id_q;
      end else if ((state_q == ST_HOLD) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef FPCVT_SAT_STATS_EN
  logic        enc_sat;
  logic [15:0] sat_cnt_q;

  fp8_encode u_enc (
    .d_i   (data_q),
    .s_o   (enc_s),
    .e_o   (enc_e),
    .f_o   (enc_f),
    .sat_o (enc_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if ((state_q == ST_CVT) && enc_sat && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  fp8_encode u_enc (
    .d_i   (data_q),
    .s_o   (enc_s),
    .e_o   (enc_e),
    .f_o   (enc_f),
    .sat_o ()
  );

  assign sat_count = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Scoreboard bench for fpcvt_arbiter: directed stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fpcvt_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [12*NREQ-1:0] req_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_s;
  logic [2:0]      out_e;
  logic [3:0]      out_f;
  logic [IDW-1:0]  out_id;
  logic            busy;
  logic [15:0]     sat_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [10:0] exp_q [$];   // {id[2:0], s, e[2:0], f[3:0]}

  // Expected {S,E,F} of the default per-requester samples 46, 63, 422, -1.
  logic [7:0] sef_of [4] = '{8'h2C, 8'h38, 8'h5D, 8'h81};

  fpcvt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_id    (out_id),
    .busy      (busy),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, required no result",
                 {out_id, out_s, out_e, out_f});
      end else begin
        chk("result", {21'd0, out_id, out_s, out_e, out_f}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic init_data();
    req_data = {12'hFFF, 12'd422, 12'd63, 12'd46};
  endtask

  // Single transaction on requester r; returns on the negedge after out_valid rises.
  task automatic issue(input int unsigned r, input logic [11:0] d,
                       input logic [7:0] sef, input bit push);
    int unsigned cyc = 0;
    @(posedge clk); #1;
    req_data[r*12 +: 12] = d;
    if (push) exp_q.push_back({3'(r), sef});
    req_valid[r] = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[r] && cyc < 20);
    chk("grant_onehot", {28'd0, req_ready}, 32'(1) << r);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    chk("latency_cvt_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_valid_high", {31'd0, out_valid}, 32'd1);
  endtask

  // Hold mask valid and expect grants seq[0..n-1], one every 2 cycles.
  task automatic run_seq(input logic [NREQ-1:0] mask, input int unsigned seq [8],
                         input int unsigned n);
    int unsigned g = 0, cyc = 0, last = 0;
    for (int unsigned k = 0; k < n; k++) exp_q.push_back({3'(seq[k]), sef_of[seq[k]]});
    @(posedge clk); #1;
    req_valid = mask;
    while (g < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        chk("rr_grant", {28'd0, req_ready}, 32'(1) << seq[g]);
        if (g > 0) chk("grant_spacing", cyc - last, 32'd2);
        last = cyc;
        g++;
      end
    end
    if (g < n) chk("rr_grant_timeout", g, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    int unsigned cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    init_data();
    #12;
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_out", {20'd0, out_valid, out_s, out_e, out_f, out_id}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sat_count", {16'd0, sat_count}, 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Conversion vectors through requester 0.
    issue(0, 12'd0,    8'h00, 1'b1);
    issue(0, 12'd422,  8'h5D, 1'b1);
    issue(0, 12'd46,   8'h2C, 1'b1);
    issue(0, 12'd63,   8'h38, 1'b1);
    issue(0, 12'd2047, 8'h7F, 1'b1);
    issue(0, 12'hFFF,  8'h81, 1'b1);
    issue(0, 12'h800,  8'hFF, 1'b1);
    drain();
    init_data();

    // Fresh pointer, all requesters contending.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_seq(4'b1111, '{0, 1, 2, 3, 0, 1, 0, 0}, 6);
    drain();

    // Move pointer to 3, then only requesters 2 and 3 contend.
    run_seq(4'b0100, '{2, 0, 0, 0, 0, 0, 0, 0}, 1);
    drain();
    run_seq(4'b1100, '{3, 2, 3, 2, 0, 0, 0, 0}, 4);
    drain();

    // Backpressure: result held, requester 1 waits.
    out_ready = 1'b0;
    issue(0, 12'd46, 8'h2C, 1'b1);
    req_valid[1] = 1'b1;
    exp_q.push_back({3'd1, 8'h38});
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_stable", {20'd0, out_valid, out_s, out_e, out_f, out_id},
          {20'd0, 1'b1, 8'h2C, 3'd0});
      chk("stall_no_grant", {28'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_grant", {28'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    issue(3, 12'hFFF, 8'h81, 1'b0);
    req_valid = 4'b0110;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {20'd0, out_valid, out_s, out_e, out_f, out_id}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("async_rst_sat", {16'd0, sat_count}, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({3'd1, 8'h38});
    @(negedge clk);
    chk("post_rst_lowest_grant", {28'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Saturation statistics.
    issue(0, 12'd2047, 8'h7F, 1'b1);
    issue(0, 12'h800,  8'hFF, 1'b1);
    issue(0, 12'd46,   8'h2C, 1'b1);
    drain();
`ifdef FPCVT_SAT_STATS_EN
    chk("sat_count", {16'd0, sat_count}, 32'd2);
`else
    chk("sat_count", {16'd0, sat_count}, 32'd0);
`endif
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
